alu_arbiter: RTL

- Shares one myalu instance among NUM_REQ requesters.
- Per-requester valid/ready request channel (A, B, opcode) and per-requester valid/ready response channel (result, carryout, overflow, zero).
- Round-robin grant; one operation in flight at a time; operands held stable at the ALU for the full ALU latency.
- Sits between the datapath clients and the myalu instance; the only driver of myalu's A/B/opcode.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package alu_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OP_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_ADDS = 3'd1;
  localparam logic [2:0] OP_SUBU = 3'd2;
  localparam logic [2:0] OP_SUBS = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_7    = 3'd7;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channels between clients and the ALU arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int OP_W    = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]  req_op;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_carryout;
  logic                     rsp_overflow;
  logic                     rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational grant picker, round-robin after i_last or lowest-index first
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  input  logic               i_fixed,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  int w_j;

  // Scan from the farthest candidate down so the closest asserted one wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_fixed) w_j = k - 1;
      else         w_j = (int'(i_last) + k) % NUM_REQ;
      if (i_req[w_j]) begin
        o_idx = IW'(w_j);
        o_any = 1'b1;
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU among NUM_REQ requesters, one op in flight
// ALU_ARB_FIXED_PRIO_EN selects lowest-index-first grant instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OP_W    = DEF_OP_W,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ALU_LAT + 1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_gidx, r_last;
  logic [WIDTH-1:0]   r_alu_a, r_alu_b, r_rsp_result;
  logic [OP_W-1:0]    r_alu_op;
  logic               r_rsp_c, r_rsp_o, r_rsp_z;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .i_fixed (FIXED),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        bus.req_ready = w_grant;
        if (w_any) w_next = S_WAIT;
      end
      S_WAIT: if (r_cnt == '0) w_next = S_RESP;
      S_RESP: begin
        bus.rsp_valid = NUM_REQ'(1) << r_gidx;
        if (bus.rsp_ready[r_gidx]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset mid-op simply abandons the captured operands; no response escapes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_gidx       <= '0;
      r_last       <= IW'(NUM_REQ - 1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_result <= '0;
      r_rsp_c      <= 1'b0;
      r_rsp_o      <= 1'b0;
      r_rsp_z      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gidx   <= w_idx;
          r_alu_a  <= bus.req_a[w_idx*WIDTH +: WIDTH];
          r_alu_b  <= bus.req_b[w_idx*WIDTH +: WIDTH];
          r_alu_op <= bus.req_op[w_idx*OP_W +: OP_W];
          r_cnt    <= CW'(ALU_LAT);
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_c      <= alu_carryout;
            r_rsp_o      <= alu_overflow;
            r_rsp_z      <= alu_zero;
          end
        end
        S_RESP: if (bus.rsp_ready[r_gidx]) r_last <= r_gidx;
        default: ;
      endcase
    end
  end

  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_opcode       = r_alu_op;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_carryout = r_rsp_c;
  assign bus.rsp_overflow = r_rsp_o;
  assign bus.rsp_zero     = r_rsp_z;

endmodule
